// File: rtl/interrupt_priority_controller.sv
// N-channel interrupt priority resolver in the style of the 8259A: IRR/ISR registers,
// edge/level capture, rotating priority, EOI commands and a one-cycle acknowledge handshake.
module interrupt_priority_controller #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               level_triggered,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               special_mask_mode,
    input  logic               special_fully_nest,
    input  logic               auto_eoi,
    input  logic               rotate_on_aeoi,
    input  logic               eoi_valid,
    input  logic               eoi_specific,
    input  logic               eoi_rotate,
    input  logic [ID_W-1:0]    eoi_id,
    input  logic               set_prio_valid,
    input  logic [ID_W-1:0]    set_prio_id,
    input  logic               ack_valid,
    output logic               int_req,
    output logic               ack_id_valid,
    output logic [ID_W-1:0]    ack_id,
    output logic               ack_spurious,
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr,
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_IRQ - 1);

    state_t             state;
    state_t             state_next;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [ID_W-1:0]    lowest_id;
    logic [ID_W-1:0]    ack_id_q;
    logic               spurious_q;

    logic [ID_W:0]      isr_top;
    logic [ID_W:0]      req_top;
    logic [ID_W:0]      blk_top;
    logic [NUM_IRQ-1:0] blk_bits;
    logic [NUM_IRQ-1:0] isr_eoi;
    logic               eoi_hit;
    logic [ID_W-1:0]    eoi_target;
    logic               cand_valid;
    logic [ID_W-1:0]    cand_id;
    logic               ack_fire;
    logic               ack_good;
    logic [NUM_IRQ-1:0] ack_clear;
    logic [NUM_IRQ-1:0] irr_next;
    logic [NUM_IRQ-1:0] isr_next;
    logic [ID_W-1:0]    lowest_next;

    function automatic logic [ID_W-1:0] wrap_id(input logic [ID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_IRQ) sum = sum - NUM_IRQ;
        return sum[ID_W-1:0];
    endfunction

    // 0 = highest priority, i.e. the id just after lowest_id.
    function automatic logic [ID_W-1:0] rank_of(input logic [ID_W-1:0] id, input logic [ID_W-1:0] low);
        int diff;
        diff = int'(id) - int'(low) - 1;
        if (diff < 0) diff = diff + NUM_IRQ;
        return diff[ID_W-1:0];
    endfunction

    // Returns {found, id} of the highest-priority set bit; the descending loop lets the
    // highest-priority hit overwrite any lower one.
    function automatic logic [ID_W:0] pick_top(input logic [NUM_IRQ-1:0] bits, input logic [ID_W-1:0] low);
        logic [ID_W:0]   top;
        logic [ID_W-1:0] id;
        top = '0;
        for (int k = NUM_IRQ; k >= 1; k--) begin
            id = wrap_id(low, k);
            if (bits[id]) top = {1'b1, id};
        end
        return top;
    endfunction

    assign isr_top = pick_top(isr, lowest_id);

    // EOI is resolved first so that a same-cycle acknowledge sees the cleared ISR.
    always_comb begin
        isr_eoi    = isr;
        eoi_hit    = 1'b0;
        eoi_target = '0;
        if (eoi_valid) begin
            if (eoi_specific) begin
                if (int'(eoi_id) < NUM_IRQ) begin
                    eoi_hit    = 1'b1;
                    eoi_target = eoi_id;
                end
            end else if (isr_top[ID_W]) begin
                eoi_hit    = 1'b1;
                eoi_target = isr_top[ID_W-1:0];
            end
        end
        if (eoi_hit) isr_eoi[eoi_target] = 1'b0;
    end

    assign req_top  = pick_top(irr & ~irq_mask, lowest_id);
    assign blk_bits = special_mask_mode ? (isr_eoi & ~irq_mask) : isr_eoi;
    assign blk_top  = pick_top(blk_bits, lowest_id);
    assign cand_id  = req_top[ID_W-1:0];

    always_comb begin
        cand_valid = 1'b0;
        if (req_top[ID_W]) begin
            if (!blk_top[ID_W]) begin
                cand_valid = 1'b1;
            end else if (rank_of(blk_top[ID_W-1:0], lowest_id) > rank_of(cand_id, lowest_id)) begin
                cand_valid = 1'b1;
            end else if ((blk_top[ID_W-1:0] == cand_id) && special_fully_nest) begin
                cand_valid = 1'b1;
            end
        end
    end

    // Handshake: ack_valid is honoured only while int_req is high (state REQ); the answer
    // (ack_id_valid with ack_id/ack_spurious) appears for exactly one cycle on the next cycle.
    assign ack_fire = (state == REQ) && ack_valid;
    assign ack_good = ack_fire && cand_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cand_valid) state_next = REQ;
            REQ: begin
                if (ack_valid)        state_next = ACK;
                else if (!cand_valid) state_next = IDLE;
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        int_req      = 1'b0;
        ack_id_valid = 1'b0;
        ack_id       = '0;
        ack_spurious = 1'b0;
        fsm_state    = state;
        if (state == REQ) int_req = 1'b1;
        if (state == ACK) begin
            ack_id_valid = 1'b1;
            ack_id       = ack_id_q;
            ack_spurious = spurious_q;
        end
    end

    // Ack ISR set is applied after the EOI clear, so a bit both acked and EOI'd ends set.
    always_comb begin
        ack_clear = '0;
        if (ack_good && !level_triggered) ack_clear[cand_id] = 1'b1;
        if (level_triggered) irr_next = irq_in;
        else                 irr_next = (irq_in & ~irq_prev) | (irr & irq_in & ~ack_clear);

        isr_next = isr_eoi;
        if (ack_good && !auto_eoi) isr_next[cand_id] = 1'b1;

        lowest_next = lowest_id;
        if (eoi_hit && eoi_rotate) begin
            lowest_next = eoi_target;
        end else if (ack_good && auto_eoi && rotate_on_aeoi) begin
            lowest_next = cand_id;
        end else if (set_prio_valid && (int'(set_prio_id) < NUM_IRQ)) begin
            lowest_next = set_prio_id;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irr        <= '0;
            isr        <= '0;
            irq_prev   <= '0;
            lowest_id  <= LAST_ID;
            ack_id_q   <= '0;
            spurious_q <= 1'b0;
        end else begin
            irr       <= irr_next;
            isr       <= isr_next;
            irq_prev  <= irq_in;
            lowest_id <= lowest_next;
            if (ack_fire) begin
                ack_id_q   <= ack_good ? cand_id : LAST_ID;
                spurious_q <= !ack_good;
            end
        end
    end

endmodule
